// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: assembles each 32-bit instruction from four byte reads.
// Define ICACHE_EN to add a direct-mapped, one-word-per-line instruction cache.
module inst_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        branch_en_in,
  input  logic [31:0] branch_target_in,
  input  logic        mem_busy_in,
  input  logic [7:0]  mem_din_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {S_A0, S_B0, S_B1, S_B2, S_B3, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [23:0] bytes_q, bytes_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [1:0]  addr_off;
  logic        fill_c;
  logic        hit_c;
  logic [31:0] hit_data_c;
  logic        unused_c;

  assign unused_c = ^{branch_target_in[1:0], 32'(ICACHE_LINES)};

`ifdef ICACHE_EN
  localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] line_valid_q;
  logic [TAG_W-1:0]        line_tag_q  [ICACHE_LINES];
  logic [31:0]             line_data_q [ICACHE_LINES];
  logic [IDX_W-1:0]        idx_c;
  logic [TAG_W-1:0]        tag_c;

  assign idx_c      = pc_q[IDX_W+1:2];
  assign tag_c      = pc_q[31:IDX_W+2];
  assign hit_c      = line_valid_q[idx_c] && (line_tag_q[idx_c] == tag_c);
  assign hit_data_c = line_data_q[idx_c];

  // Valid bits survive redirects; only reset invalidates the cache
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_valid_q <= '0;
    end else if (fill_c) begin
      line_valid_q[idx_c] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_c) begin
      line_tag_q[idx_c]  <= tag_c;
      line_data_q[idx_c] <= {mem_din_in, bytes_q};
    end
  end
`else
  assign hit_c      = 1'b0;
  assign hit_data_c = 32'h0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_A0;
      pc_q     <= {RESET_PC[31:2], 2'b00};
      bytes_q  <= '0;
      inst_q   <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      bytes_q  <= bytes_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    bytes_d     = bytes_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    mem_req_out = 1'b0;
    addr_off    = 2'd0;
    fill_c      = 1'b0;

    case (state_q)
      S_A0: begin
        if (hit_c) begin
          inst_d   = hit_data_c;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          state_d  = S_HOLD;
        end else if (!mem_busy_in) begin
          mem_req_out = 1'b1;
          state_d     = S_B0;
        end
      end
      // Bytes shift in from the top so b0 lands in the low byte after three captures
      S_B0: begin
        bytes_d     = {mem_din_in, bytes_q[23:8]};
        mem_req_out = 1'b1;
        addr_off    = 2'd1;
        state_d     = S_B1;
      end
      S_B1: begin
        bytes_d     = {mem_din_in, bytes_q[23:8]};
        mem_req_out = 1'b1;
        addr_off    = 2'd2;
        state_d     = S_B2;
      end
      S_B2: begin
        bytes_d     = {mem_din_in, bytes_q[23:8]};
        mem_req_out = 1'b1;
        addr_off    = 2'd3;
        state_d     = S_B3;
      end
      S_B3: begin
        inst_d   = {mem_din_in, bytes_q};
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        fill_c   = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (!stall_in) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = S_A0;
        end
      end
      default: state_d = S_A0;
    endcase

    // Redirect wins over hit, busy and consume; the captured word is discarded
    if (branch_en_in) begin
      pc_d        = {branch_target_in[31:2], 2'b00};
      state_d     = S_A0;
      valid_d     = 1'b0;
      inst_d      = inst_q;
      pc_out_d    = pc_out_q;
      mem_req_out = 1'b0;
      fill_c      = 1'b0;
    end

    if (rst_in) begin
      mem_req_out = 1'b0;
    end

    mem_addr_out = mem_req_out ? {pc_q[31:2], addr_off} : 32'h0;
  end

  assign inst_valid_out = valid_q;
  assign inst_out       = inst_q;
  assign pc_out         = pc_out_q;

endmodule
